instr_mem_responder: RTL and testbench

Responder side of the instruction-fetch request/grant/valid protocol. It serves fetch requests issued by the IF stage's fetch unit. The block accepts requests, reads a word-addressed instruction store, and returns data in order after a fixed, parameterised latency. A preload write port allows the testbench or boot logic to load a program image. The block supports flush-driven cancellation of in-flight responses and flags erroneous addresses.

---
 rtl/instr_mem_responder_pkg.sv | 31 +++
 rtl/instr_mem_responder_resp_pipe.sv | 47 ++++
 rtl/instr_mem_responder.sv | 126 ++++++++++++
 tb/tb_instr_mem_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_responder_pkg
// Shared types and constants for the instruction-fetch responder.
//   NOP_INSTR   : instruction returned for erroneous fetch addresses
//   mem_resp_t  : one response-pipe entry {valid, err, data}
//   RESP_IDLE   : all-zero entry; idle outputs are forced to this value
//   addr_bad()  : misaligned or out-of-range word address decode
// -----------------------------------------------------------------------------
package instr_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } mem_resp_t;

    localparam mem_resp_t RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: '0};

    // Address is bad when not word aligned or when its word index is past the store.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth_words);
        return (addr[1:0] != 2'b00) ||
               ({1'b0, addr[ADDR_W-1:2]} >= 31'(depth_words));
    endfunction

endpackage : instr_mem_responder_pkg

// File: rtl/instr_mem_responder_resp_pipe.sv
// -----------------------------------------------------------------------------
// instr_resp_pipe
// LATENCY-deep shift register of mem_resp_t entries. Entry written at the
// input appears on resp_op exactly LATENCY edges later. A synchronous clear
// empties every stage at the next edge; the entry already on resp_op is still
// presented during the clear cycle because the output is a stage register.
//   clock    : rising-edge clock
//   clear    : synchronous clear of all stages (reset | flush)
//   resp_ip  : entry entering stage 1
//   resp_op  : final-stage entry (registered)
// -----------------------------------------------------------------------------
module instr_resp_pipe
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic      clock,
    input  logic      clear,
    input  mem_resp_t resp_ip,
    output mem_resp_t resp_op
);

    mem_resp_t stage_q [LATENCY];
    mem_resp_t stage_d [LATENCY];

    // Next-state: shift by one stage, or empty everything on clear.
    always_comb begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_d[i] = RESP_IDLE;
        end
        if (!clear) begin
            stage_d[0] = resp_ip;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
        end
    end

    assign resp_op = stage_q[LATENCY-1];

endmodule : instr_resp_pipe

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
// Responder side of the instruction-fetch req/gnt/valid protocol. Grants
// requests combinationally, reads a word-addressed store in the grant cycle and
// returns the word in order LATENCY cycles later. A preload port writes the
// store; flush and reset drop every in-flight response.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   mem_en           : low blocks new grants (in-flight responses still drain)
//   instr_req_ip     : fetch request, held by the requester until granted
//   instr_addr_ip    : fetch byte address
//   flush_ip         : cancel all in-flight responses
//   load_en_ip/addr/data : preload write port (has priority over fetch)
//   instr_gnt_op     : request accepted this cycle (combinational)
//   instr_valid_op   : response valid (registered)
//   instr_data_op    : returned word, NOP_INSTR on error, 0 when idle
//   instr_err_op     : response belongs to a bad address
// -----------------------------------------------------------------------------
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        instr_req_ip,
    input  logic [31:0] instr_addr_ip,
    input  logic        flush_ip,
    input  logic        load_en_ip,
    input  logic [31:0] load_addr_ip,
    input  logic [31:0] load_data_ip,
    output logic        instr_gnt_op,
    output logic        instr_valid_op,
    output logic [31:0] instr_data_op,
    output logic        instr_err_op
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_bad;
    logic             wr_bad;
    logic             mem_we;
    logic             gnt;
    logic             pipe_clear;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_live;
    mem_resp_t        rsp_in;
    mem_resp_t        rsp_out;

    // Address decode for the fetch and preload ports.
    assign rd_idx = instr_addr_ip[IDX_W+1:2];
    assign wr_idx = load_addr_ip[IDX_W+1:2];
    assign rd_bad = addr_bad(instr_addr_ip, DEPTH_WORDS);
    assign wr_bad = addr_bad(load_addr_ip, DEPTH_WORDS);
    assign mem_we = load_en_ip & ~wr_bad;

    // A response leaving the pipe this cycle already frees its slot, so a held
    // request is granted in the very cycle the oldest response is returned.
    assign cnt_live = cnt_q - CNT_W'(rsp_out.valid);

    assign gnt = instr_req_ip & mem_en & ~reset & ~flush_ip & ~load_en_ip &
                 (cnt_live < CNT_W'(MAX_OUTSTANDING));

    assign pipe_clear = reset | flush_ip;

    // Stage-1 entry: the read word, or NOP with err for a bad address.
    always_comb begin
        rsp_in = RESP_IDLE;
        if (gnt) begin
            rsp_in.valid = 1'b1;
            rsp_in.err   = rd_bad;
            rsp_in.data  = rd_bad ? NOP_INSTR : mem_q[rd_idx];
        end
    end

    // Outstanding count: +1 on grant, -1 on return, cleared by flush.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !rsp_out.valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!gnt && rsp_out.valid) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (flush_ip) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Instruction store; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_idx] <= load_data_ip;
        end
    end

    instr_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clock   (clock),
        .clear   (pipe_clear),
        .resp_ip (rsp_in),
        .resp_op (rsp_out)
    );

    assign instr_gnt_op   = gnt;
    assign instr_valid_op = rsp_out.valid;
    assign instr_err_op   = rsp_out.err;
    assign instr_data_op  = rsp_out.data;

endmodule : instr_mem_responder

// File: tb/tb_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_responder
// Self-checking bench for instr_mem_responder with default parameters. A
// reference model keeps a queue of pending responses (each with its due cycle)
// and a copy of the store; each test task drives stimulus and compares the DUT
// against the model, plus a few directed expectations.
// -----------------------------------------------------------------------------
module tb_instr_mem_responder;
    import instr_mem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int MAXO  = 2;
    localparam int IDX_W = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        instr_req_ip;
    logic [31:0] instr_addr_ip;
    logic        flush_ip;
    logic        load_en_ip;
    logic [31:0] load_addr_ip;
    logic [31:0] load_data_ip;
    logic        instr_gnt_op;
    logic        instr_valid_op;
    logic [31:0] instr_data_op;
    logic        instr_err_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } pend_t;

    pend_t       pend [$];
    logic [31:0] ref_mem [DEPTH];

    always #5 clock = ~clock;

    instr_mem_responder #(
        .DEPTH_WORDS     (DEPTH),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_en         (mem_en),
        .instr_req_ip   (instr_req_ip),
        .instr_addr_ip  (instr_addr_ip),
        .flush_ip       (flush_ip),
        .load_en_ip     (load_en_ip),
        .load_addr_ip   (load_addr_ip),
        .load_data_ip   (load_data_ip),
        .instr_gnt_op   (instr_gnt_op),
        .instr_valid_op (instr_valid_op),
        .instr_data_op  (instr_data_op),
        .instr_err_op   (instr_err_op)
    );

    // ---------------- reference model ----------------
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    function automatic logic exp_valid();
        return (pend.size() != 0) && (pend[0].due == cyc);
    endfunction

    function automatic logic exp_gnt();
        int live;
        live = pend.size() - (exp_valid() ? 1 : 0);
        return instr_req_ip && mem_en && !reset && !flush_ip && !load_en_ip && (live < MAXO);
    endfunction

    function automatic logic [34:0] exp_vec();
        logic v;
        v = exp_valid();
        return {exp_gnt(), v, v ? pend[0].err : 1'b0, v ? pend[0].data : 32'h0};
    endfunction

    function automatic logic [34:0] obs();
        return {instr_gnt_op, instr_valid_op, instr_err_op, instr_data_op};
    endfunction

    // Apply this cycle's inputs to the model, then cross the clock edge.
    task automatic advance();
        logic  v;
        logic  g;
        pend_t p;
        v = exp_valid();
        g = exp_gnt();
        p.due  = cyc + LAT;
        p.err  = bad_addr(instr_addr_ip);
        p.data = p.err ? NOP_INSTR : ref_mem[instr_addr_ip[IDX_W+1:2]];
        if (load_en_ip && !bad_addr(load_addr_ip)) ref_mem[load_addr_ip[IDX_W+1:2]] = load_data_ip;
        if (v) void'(pend.pop_front());
        if (reset || flush_ip) pend.delete();
        if (g) pend.push_back(p);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; mem_en = 1'b1; instr_req_ip = 1'b0; instr_addr_ip = '0;
        flush_ip = 1'b0; load_en_ip = 1'b0; load_addr_ip = '0; load_data_ip = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; mem_en = 1'b1; instr_req_ip = 1'b1; instr_addr_ip = 32'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            checks++;
            if (obs() !== 35'h0) begin
                errors++; $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, obs());
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) begin
            load_en_ip   = 1'b1;
            load_addr_ip = 32'(i) << 2;
            load_data_ip = (i == 4) ? 32'hDEAD_BEEF : $urandom();
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL preload cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) begin
            instr_req_ip = (i == 0); instr_addr_ip = 32'h10;
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (instr_gnt_op !== 1'b1) begin
                    errors++; $display("FAIL single_gnt got=%b exp=1", instr_gnt_op);
                end
            end
            if (i == 2 || i == 3) begin
                checks++;
                if ({instr_valid_op, instr_err_op, instr_data_op} !==
                    ((i == 2) ? {2'b10, 32'hDEAD_BEEF} : 34'h0)) begin
                    errors++; $display("FAIL single_resp i=%0d got=%b/%b/%h", i,
                                       instr_valid_op, instr_err_op, instr_data_op);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [$];
        logic        g;
        addrs = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 8; i++) begin
            instr_req_ip = (addrs.size() != 0);
            if (addrs.size() != 0) instr_addr_ip = addrs[0];
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i == 2) begin
                checks++;
                if ({instr_gnt_op, instr_valid_op} !== 2'b11) begin
                    errors++; $display("FAIL b2b_slot_free got=%b%b exp=11", instr_gnt_op, instr_valid_op);
                end
            end
            g = exp_gnt();
            advance();
            if (g) void'(addrs.pop_front());
        end
        idle_inputs();
    endtask

    task automatic test_bad_addr();
        logic [31:0] addrs [$];
        logic        g;
        addrs = '{32'h6, 32'(4 * DEPTH)};
        for (int i = 0; i < 6; i++) begin
            instr_req_ip = (addrs.size() != 0);
            if (addrs.size() != 0) instr_addr_ip = addrs[0];
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL bad_addr cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i == 2 || i == 3) begin
                checks++;
                if ({instr_valid_op, instr_err_op, instr_data_op} !== {2'b11, NOP_INSTR}) begin
                    errors++; $display("FAIL bad_addr_nop i=%0d got=%b/%b/%h", i,
                                       instr_valid_op, instr_err_op, instr_data_op);
                end
            end
            g = exp_gnt();
            advance();
            if (g) void'(addrs.pop_front());
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            instr_req_ip  = (i == 0) || (i == 2);
            instr_addr_ip = (i == 0) ? 32'h20 : 32'h24;
            flush_ip      = (i == 1);
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL flush cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i == 2) begin
                checks++;
                if ({instr_gnt_op, instr_valid_op} !== 2'b10) begin
                    errors++; $display("FAIL flush_drop got=%b%b exp=10", instr_gnt_op, instr_valid_op);
                end
            end
            if (i == 4) begin
                checks++;
                if (instr_valid_op !== 1'b1) begin
                    errors++; $display("FAIL flush_after got=%b exp=1", instr_valid_op);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_load_priority();
        logic [31:0] word;
        word = $urandom();
        for (int i = 0; i < 5; i++) begin
            load_en_ip = (i == 0); load_addr_ip = 32'h30; load_data_ip = word;
            instr_req_ip = (i <= 1); instr_addr_ip = 32'h30;
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL load_prio cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i <= 1) begin
                checks++;
                if (instr_gnt_op !== (i == 1)) begin
                    errors++; $display("FAIL load_prio_gnt i=%0d got=%b", i, instr_gnt_op);
                end
            end
            if (i == 3) begin
                checks++;
                if ({instr_valid_op, instr_data_op} !== {1'b1, word}) begin
                    errors++; $display("FAIL load_prio_data got=%b/%h exp=1/%h", instr_valid_op, instr_data_op, word);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            instr_req_ip = (i == 0); instr_addr_ip = 32'h40; reset = (i == 1);
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i >= 2) begin
                checks++;
                if ({instr_valid_op, instr_err_op, instr_data_op} !== 34'h0) begin
                    errors++; $display("FAIL reset_mid_drop i=%0d got=%b/%b/%h", i,
                                       instr_valid_op, instr_err_op, instr_data_op);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_mem_en();
        for (int i = 0; i < 10; i++) begin
            mem_en = (i >= 6); instr_req_ip = (i <= 6); instr_addr_ip = 32'h8;
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL mem_en cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            if (i < 6) begin
                checks++;
                if (instr_gnt_op !== 1'b0) begin
                    errors++; $display("FAIL mem_en_block i=%0d got=%b exp=0", i, instr_gnt_op);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic g;
        g = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (g || !instr_req_ip) begin
                instr_req_ip  = ($urandom_range(0, 3) != 0);
                instr_addr_ip = ($urandom_range(0, 9) == 0) ? $urandom()
                                                            : (32'($urandom_range(0, DEPTH - 1)) << 2);
            end
            flush_ip     = ($urandom_range(0, 19) == 0);
            load_en_ip   = ($urandom_range(0, 14) == 0);
            load_addr_ip = ($urandom_range(0, 7) == 0) ? $urandom()
                                                       : (32'($urandom_range(0, DEPTH - 1)) << 2);
            load_data_ip = $urandom();
            mem_en       = ($urandom_range(0, 9) != 0);
            reset        = ($urandom_range(0, 99) == 0);
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            g = exp_gnt();
            advance();
        end
        idle_inputs();
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clock); checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        idle_inputs();
        reset  = 1'b1;
        mem_en = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_preload();
        test_single();
        test_back_to_back();
        test_bad_addr();
        test_flush();
        test_load_priority();
        test_reset_mid();
        test_mem_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_mem_responder
